card_row_pixel_gen: RTL and testbench

- Upstream feeder and downstream compositor for the card-pixel memory stage, which maps (6-bit local x, 6-bit local y, 6-bit card type) to a 12-bit pixel with one clock of block-RAM latency.
- Holds a table of NUM_SLOTS card slots laid out as one horizontal row on screen.
- From the VGA scan counters it computes the slot hit and the local coordinates, drives the memory stage, and takes its pixel back one cycle later.
- Merges that pixel with background, empty-slot and selection colouring, then emits a pipelined RGB pixel.

---
 rtl/card_row_pixel_gen.sv | 114 +++++++++++
 tb/tb_card_row_pixel_gen.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/card_row_pixel_gen.sv
// Card-row feeder/compositor: maps VGA scan position to a slot in a horizontal card row,
// addresses the card-pixel memory stage and merges its pixel. Optional macro: CARD_HILITE_EN.
module card_row_pixel_gen #(
    parameter int          NUM_SLOTS    = 20,
    parameter int          ROW_X0       = 0,
    parameter int          ROW_Y0       = 400,
    parameter logic [11:0] BG_COLOR     = 12'h0A4,
    parameter logic [11:0] HILITE_COLOR = 12'hFF0
) (
    input  logic        clk_25MHz,
    input  logic        rst_n,
    input  logic [9:0]  h_cnt,
    input  logic [9:0]  v_cnt,
    input  logic        valid,
    input  logic        slot_wr_en,
    input  logic [4:0]  slot_wr_idx,
    input  logic [5:0]  slot_wr_type,
    input  logic        slot_clr,
    input  logic [4:0]  sel_idx,
    input  logic        sel_en,
    output logic [5:0]  pixel_x,
    output logic [5:0]  pixel_y,
    output logic [5:0]  card_type,
    input  logic [11:0] card_pixel,
    output logic [11:0] rgb_out,
    output logic        rgb_valid
);

    localparam logic [10:0] X0    = 11'(ROW_X0);
    localparam logic [10:0] X1    = 11'(ROW_X0 + 32 * NUM_SLOTS);
    localparam logic [10:0] Y0    = 11'(ROW_Y0);
    localparam logic [10:0] Y1    = 11'(ROW_Y0 + 46);
    localparam logic [5:0]  NSL   = 6'(NUM_SLOTS);
    localparam logic [5:0]  EMPTY = 6'd63;

    logic [5:0]  r_slots [NUM_SLOTS];
    logic [5:0]  r_pixel_x, r_pixel_y, r_card_type;
    logic [2:0]  r_vld_pipe;
    logic        r_s1_hit, r_s1_empty, r_s1_border;
    logic        r_s2_hit, r_s2_empty, r_s2_border;
    logic [11:0] r_rgb;

    logic [10:0] w_hoff, w_voff;
    logic [4:0]  w_slot;
    logic        w_hit, w_border;
    logic [5:0]  w_type;

    assign w_hoff = {1'b0, h_cnt} - X0;
    assign w_voff = {1'b0, v_cnt} - Y0;
    assign w_slot = w_hoff[9:5];
    assign w_hit  = valid && ({1'b0, h_cnt} >= X0) && ({1'b0, h_cnt} < X1)
                          && ({1'b0, v_cnt} >= Y0) && ({1'b0, v_cnt} < Y1);
    assign w_type = ({1'b0, w_slot} < NSL) ? r_slots[w_slot] : EMPTY;

`ifdef CARD_HILITE_EN
    assign w_border = (w_hoff[4:0] == 5'd0 || w_hoff[4:0] == 5'd31 ||
                       w_voff[5:0] == 6'd0 || w_voff[5:0] == 6'd45) &&
                      sel_en && (w_slot == sel_idx) && ({1'b0, sel_idx} < NSL);
`else
    assign w_border = 1'b0;
    wire w_unused_sel = &{1'b0, sel_idx, sel_en};
`endif
    wire w_unused_bits = &{1'b0, w_hoff[10], w_voff[10:6]};

    // Table read in S1 sees the pre-write value; writes land on the same edge.
    always_ff @(posedge clk_25MHz or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_SLOTS; i++) r_slots[i] <= EMPTY;
        end else if (slot_clr) begin
            for (int i = 0; i < NUM_SLOTS; i++) r_slots[i] <= EMPTY;
        end else if (slot_wr_en && ({1'b0, slot_wr_idx} < NSL)) begin
            r_slots[slot_wr_idx] <= slot_wr_type;
        end
    end

    always_ff @(posedge clk_25MHz or negedge rst_n) begin
        if (!rst_n) begin
            r_pixel_x   <= 6'd0;
            r_pixel_y   <= 6'd0;
            r_card_type <= EMPTY;
            r_vld_pipe  <= 3'b000;
            r_s1_hit    <= 1'b0;
            r_s1_empty  <= 1'b0;
            r_s1_border <= 1'b0;
            r_s2_hit    <= 1'b0;
            r_s2_empty  <= 1'b0;
            r_s2_border <= 1'b0;
            r_rgb       <= 12'd0;
        end else begin
            r_pixel_x   <= {1'b0, w_hoff[4:0]};
            r_pixel_y   <= w_voff[5:0];
            r_card_type <= w_hit ? w_type : EMPTY;
            r_vld_pipe  <= {r_vld_pipe[1:0], valid};
            r_s1_hit    <= w_hit;
            r_s1_empty  <= (w_type == EMPTY);
            r_s1_border <= w_border;
            r_s2_hit    <= r_s1_hit;
            r_s2_empty  <= r_s1_empty;
            r_s2_border <= r_s1_border;
            // card_pixel now belongs to the address issued in S1
            if (!r_vld_pipe[1])               r_rgb <= 12'd0;
            else if (!r_s2_hit || r_s2_empty) r_rgb <= BG_COLOR;
            else if (r_s2_border)             r_rgb <= HILITE_COLOR;
            else                              r_rgb <= card_pixel;
        end
    end

    assign pixel_x   = r_pixel_x;
    assign pixel_y   = r_pixel_y;
    assign card_type = r_card_type;
    assign rgb_out   = r_rgb;
    assign rgb_valid = r_vld_pipe[2];

endmodule

// File: tb/tb_card_row_pixel_gen.sv
// Bench for card_row_pixel_gen: spec-level model with per-cycle compare plus directed literal checks.
module tb_card_row_pixel_gen;
    localparam int          NS     = 20;
    localparam int          RX0    = 0;
    localparam int          RY0    = 400;
    localparam logic [11:0] BG     = 12'h0A4;
    localparam logic [11:0] HILITE = 12'hFF0;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [9:0]  h_cnt = '0, v_cnt = '0;
    logic        valid = 1'b0;
    logic        slot_wr_en = 1'b0, slot_clr = 1'b0, sel_en = 1'b0;
    logic [4:0]  slot_wr_idx = '0, sel_idx = '0;
    logic [5:0]  slot_wr_type = '0;
    logic [5:0]  pixel_x, pixel_y, card_type;
    logic [11:0] card_pixel = '0;
    logic [11:0] rgb_out;
    logic        rgb_valid;

    int n_cmp = 0, n_bad = 0;
    logic chk_en = 1'b0;

    card_row_pixel_gen #(.NUM_SLOTS(NS), .ROW_X0(RX0), .ROW_Y0(RY0),
                         .BG_COLOR(BG), .HILITE_COLOR(HILITE)) dut (
        .clk_25MHz(clk), .rst_n(rst_n), .h_cnt(h_cnt), .v_cnt(v_cnt), .valid(valid),
        .slot_wr_en(slot_wr_en), .slot_wr_idx(slot_wr_idx), .slot_wr_type(slot_wr_type),
        .slot_clr(slot_clr), .sel_idx(sel_idx), .sel_en(sel_en),
        .pixel_x(pixel_x), .pixel_y(pixel_y), .card_type(card_type),
        .card_pixel(card_pixel), .rgb_out(rgb_out), .rgb_valid(rgb_valid));

    always #20 clk = ~clk;

    // Memory-stage stub: one cycle of latency, pixel = {6'd0, type}
    always @(posedge clk) card_pixel <= {6'd0, card_type};

    task automatic chk(input string nm, input logic [11:0] act, input logic [11:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: the spec's rules in plain arithmetic, delayed by a 3-deep queue
    logic [5:0]  mtab [NS];
    logic [11:0] p1 = '0, p2 = '0, p3 = '0, m_e;
    logic        v1 = 1'b0, v2 = 1'b0, v3 = 1'b0, m_in;
    logic [5:0]  ax = '0, ay = '0, act = 6'd63, m_ty;
    int          m_hx, m_vy, m_slot;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NS; i++) mtab[i] = 6'd63;
            p1 = '0; p2 = '0; p3 = '0; v1 = 0; v2 = 0; v3 = 0;
            ax = '0; ay = '0; act = 6'd63;
        end else begin
            m_hx   = int'(h_cnt) - RX0;
            m_vy   = int'(v_cnt) - RY0;
            m_in   = valid && m_hx >= 0 && m_hx < 32 * NS && m_vy >= 0 && m_vy < 46;
            m_slot = m_in ? m_hx / 32 : 0;
            m_ty   = m_in ? mtab[m_slot] : 6'd63;
            if (!valid) m_e = 12'd0;
            else if (!m_in || m_ty == 6'd63) m_e = BG;
            else begin
                m_e = {6'd0, m_ty};
`ifdef CARD_HILITE_EN
                if (sel_en && int'(sel_idx) == m_slot &&
                    (m_hx % 32 == 0 || m_hx % 32 == 31 || m_vy == 0 || m_vy == 45))
                    m_e = HILITE;
`endif
            end
            p3 = p2; p2 = p1; p1 = m_e;
            v3 = v2; v2 = v1; v1 = valid;
            ax = 6'(m_hx & 31); ay = 6'(m_vy & 63); act = m_ty;
            if (slot_clr) for (int i = 0; i < NS; i++) mtab[i] = 6'd63;
            else if (slot_wr_en && int'(slot_wr_idx) < NS) mtab[slot_wr_idx] = slot_wr_type;
        end
    end

    always @(negedge clk) if (chk_en) begin
        chk("m_rgb_out",   rgb_out, p3);
        chk("m_rgb_valid", {11'd0, rgb_valid}, {11'd0, v3});
        chk("m_pixel_x",   {6'd0, pixel_x}, {6'd0, ax});
        chk("m_pixel_y",   {6'd0, pixel_y}, {6'd0, ay});
        chk("m_card_type", {6'd0, card_type}, {6'd0, act});
    end

    task automatic wr(input int idx, input int ty, input logic clr);
        @(negedge clk);
        slot_wr_en = 1'b1; slot_wr_idx = 5'(idx); slot_wr_type = 6'(ty); slot_clr = clr;
        @(negedge clk);
        slot_wr_en = 1'b0; slot_clr = 1'b0;
    endtask

    // Single isolated pixel; address checked after S1, colour after 3 edges
    task automatic px(input string nm, input int h, input int v, input logic vl,
                      input int ect, input logic [11:0] exp);
        @(negedge clk);
        h_cnt = 10'(h); v_cnt = 10'(v); valid = vl;
        @(negedge clk);
        valid = 1'b0; h_cnt = '0; v_cnt = '0;
        if (ect >= 0) chk({nm, "_ct"}, {6'd0, card_type}, 12'(ect));
        @(negedge clk);
        @(negedge clk);
        chk(nm, rgb_out, exp);
        chk({nm, "_vld"}, {11'd0, rgb_valid}, {11'd0, vl});
    endtask

    initial begin
        #3 rst_n = 1'b0;
        #2;
        chk("rst_rgb", rgb_out, 12'd0);
        chk("rst_vld", {11'd0, rgb_valid}, 12'd0);
        chk("rst_ct",  {6'd0, card_type}, 12'd63);
        chk_en = 1'b1;
        #100 rst_n = 1'b1;

        px("empty_row", 70, 410, 1'b1, 63, BG);

        wr(2, 14, 1'b0);
        @(negedge clk); h_cnt = 10'd70; v_cnt = 10'd410; valid = 1'b1;
        @(negedge clk); valid = 1'b0;
        chk("s1_px", {6'd0, pixel_x}, 12'd6);
        chk("s1_py", {6'd0, pixel_y}, 12'd10);
        chk("s1_ct", {6'd0, card_type}, 12'd14);
        @(negedge clk); @(negedge clk);
        chk("s3_rgb", rgb_out, 12'h00E);

        wr(0, 7, 1'b0);
        px("h639", 639, 410, 1'b1, 63, BG);
        px("v399", 0, 399, 1'b1, 63, BG);
        @(negedge clk); h_cnt = 10'd0; v_cnt = 10'd445; valid = 1'b1;
        @(negedge clk); valid = 1'b0;
        chk("v445_py", {6'd0, pixel_y}, 12'd45);
        @(negedge clk); @(negedge clk);
        chk("v445_rgb", rgb_out, 12'h007);
        px("v446", 0, 446, 1'b1, 63, BG);
        px("novalid", 70, 410, 1'b0, 63, 12'd0);

        wr(25, 5, 1'b0);
        px("idx25_s9", 290, 410, 1'b1, 63, BG);
        px("idx25_s5", 161, 410, 1'b1, 63, BG);

        // Write slot 0 while the same slot is being scanned
        @(negedge clk);
        h_cnt = 10'd5; v_cnt = 10'd410; valid = 1'b1;
        slot_wr_en = 1'b1; slot_wr_idx = 5'd0; slot_wr_type = 6'd20;
        @(negedge clk); h_cnt = 10'd6; slot_wr_en = 1'b0;
        chk("rw_old_ct", {6'd0, card_type}, 12'd7);
        @(negedge clk); valid = 1'b0;
        chk("rw_new_ct", {6'd0, card_type}, 12'd20);
        @(negedge clk); chk("rw_old_rgb", rgb_out, 12'h007);
        @(negedge clk); chk("rw_new_rgb", rgb_out, 12'h014);

        wr(3, 9, 1'b0);
        wr(3, 11, 1'b1);
        px("clr_s3", 100, 410, 1'b1, 63, BG);
        px("clr_s0", 5, 410, 1'b1, 63, BG);

        wr(1, 33, 1'b0);
        sel_idx = 5'd1; sel_en = 1'b1;
`ifdef CARD_HILITE_EN
        px("hl_edge", 32, 420, 1'b1, 33, HILITE);
`else
        px("hl_edge", 32, 420, 1'b1, 33, 12'h021);
`endif
        px("hl_inner", 40, 420, 1'b1, 33, 12'h021);
        sel_en = 1'b0;
        px("hl_off_edge", 32, 420, 1'b1, 33, 12'h021);
        px("hl_off_inner", 40, 420, 1'b1, 33, 12'h021);

        // Populated row scanned across its full height and width, with blanking
        for (int i = 0; i < NS; i += 2) wr(i, (i * 3) % 63, 1'b0);
        wr(7, 58, 1'b0);
        sel_idx = 5'd4; sel_en = 1'b1;
        for (int v = 396; v < 450; v++) begin
            if (v == 425) sel_idx = 5'd25;
            for (int h = 0; h < 644; h++) begin
                @(negedge clk);
                h_cnt = 10'(h); v_cnt = 10'(v); valid = (h < 640);
            end
        end

        // Reset in the middle of a scanned row
        for (int h = 0; h < 100; h++) begin
            @(negedge clk);
            h_cnt = 10'(h); v_cnt = 10'd410; valid = 1'b1;
            if (h == 50) begin
                #5 rst_n = 1'b0;
                #1;
                chk("mid_rst_rgb", rgb_out, 12'd0);
                chk("mid_rst_vld", {11'd0, rgb_valid}, 12'd0);
                chk("mid_rst_ct",  {6'd0, card_type}, 12'd63);
            end
            if (h == 53) rst_n = 1'b1;
        end
        valid = 1'b0;
        px("post_rst", 70, 410, 1'b1, 63, BG);

        repeat (4) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
